// File: rtl/dm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dm_ctrl
//  Purpose  : Data-memory access controller. Converts a single-cycle
//             load/store request into a mem_req/mem_ack handshake with byte
//             enables, lane-replicated store data and a registered,
//             sign/zero-extended load result for the writeback mux.
//  Revision : 1.0  initial release
// ============================================================================
module dm_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        W_DM,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [31:0] out_DM,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // Wait-cycle limit widened by one bit so the compare never overflows at 255.
    localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] out_q, out_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;

    logic        req_bad;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Validate the incoming request and format its byte enables and store data.
    always_comb begin
        req_bad   = 1'b0;
        req_be    = 4'b0000;
        req_wdata = 32'h0;
        case (size)
            2'b00: begin
                req_be    = 4'b0001 << in_addr[1:0];
                req_wdata = {4{in_data[7:0]}};
            end
            2'b01: begin
                req_bad   = in_addr[0];
                req_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{in_data[15:0]}};
            end
            2'b10: begin
                req_bad   = |in_addr[1:0];
                req_be    = 4'b1111;
                req_wdata = in_data;
            end
            default: begin
                req_bad   = 1'b1;
            end
        endcase
    end

    // Pick the addressed lane(s) out of the read word and extend to 32 bits.
    always_comb begin
        ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{sext_q & ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next-state logic; memory outputs fall to zero unless WAIT is (re)entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        size_d      = size_q;
        sext_d      = sext_q;
        out_d       = out_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'h0;
        mem_wdata_d = 32'h0;
        mem_be_d    = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_bad) begin
                        state_d = S_ERR;
                    end else begin
                        state_d     = S_WAIT;
                        cnt_d       = 8'd0;
                        lane_d      = in_addr[1:0];
                        size_d      = size;
                        sext_d      = sign_ext;
                        mem_req_d   = 1'b1;
                        mem_we_d    = W_DM;
                        mem_addr_d  = {in_addr[31:2], 2'b00};
                        mem_wdata_d = req_wdata;
                        mem_be_d    = req_be;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    // Ack takes priority over a coincident timeout.
                    state_d = S_DONE;
                    if (!mem_we_q) begin
                        out_d = ld_ext;
                    end
                end else if (({1'b0, cnt_q} + 9'd1) == TO_LIM) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d       = cnt_q + 8'd1;
                    mem_req_d   = mem_req_q;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                    mem_be_d    = mem_be_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the bus immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
            out_q       <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'b0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            out_q       <= out_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign out_DM    = out_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule
`default_nettype wire
